// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with clear, clamped load, saturate/wrap mode,
// terminal count, wrap pulse and saturating wrap counter. Optional enable
// prescaler is built when COUNTER_PRESCALE_EN is defined.
module mod_updown_counter #(
  parameter int WIDTH    = 3,
  parameter int MOD      = 2**WIDTH,
  parameter int WRAP_W   = 4,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              sat,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  count,
  output logic              tc,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt
);

  if (MOD < 2 || MOD > 2**WIDTH || PRESCALE < 1) begin : g_bad_param
    $fatal(1, "mod_updown_counter: illegal MOD/PRESCALE");
  end

  localparam logic [WIDTH:0]   MAX   = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] MAX_W = MAX[WIDTH-1:0];

  logic [WIDTH-1:0]  count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              en_eff;

`ifdef COUNTER_PRESCALE_EN
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] div_q, div_d;

  assign en_eff = en && (div_q == PS_LAST);

  always_comb begin
    div_d = div_q;
    if (clr || load)  div_d = '0;
    else if (en)      div_d = en_eff ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end
`else
  assign en_eff = en;
`endif

  logic [WIDTH:0] cnt_x;
  logic           wrap_set;

  always_comb begin
    count_d    = count_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_set   = 1'b0;
    cnt_x      = {1'b0, count_q};
    if (clr) begin
      count_d    = '0;
      wrap_cnt_d = '0;
    end else if (load) begin
      count_d = ({1'b0, load_val} > MAX) ? MAX_W : load_val;
    end else if (en_eff) begin
      if (up) begin
        if (cnt_x < MAX)  count_d = WIDTH'(cnt_x + 1'b1);
        else if (!sat) begin
          count_d  = '0;
          wrap_set = 1'b1;
        end
      end else begin
        if (cnt_x != '0)  count_d = WIDTH'(cnt_x - 1'b1);
        else if (!sat) begin
          count_d  = MAX_W;
          wrap_set = 1'b1;
        end
      end
    end
    wrap_d = wrap_set;
    // wrap counter sticks at all-ones rather than rolling over
    if (wrap_set && (wrap_cnt_q != '1)) wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign wrap_cnt = wrap_cnt_q;
  assign tc       = en_eff & (up ? (count_q == MAX_W) : (count_q == '0));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter (WIDTH=3, MOD=6, WRAP_W=2).
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, en = 1'b0, up = 1'b0, sat = 1'b0, clr = 1'b0, load = 1'b0;
  logic [2:0] load_val = '0;
  logic [2:0] count;
  logic       tc, wrap;
  logic [1:0] wrap_cnt;

  mod_updown_counter #(.WIDTH(3), .MOD(6), .WRAP_W(2), .PRESCALE(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .sat(sat), .clr(clr),
    .load(load), .load_val(load_val), .count(count), .tc(tc), .wrap(wrap),
    .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  // tc: expected during the cycle the inputs are applied;
  // cnt/wr/wc: expected once the following edge has consumed them
  typedef struct {
    bit         tc;
    logic [2:0] cnt;
    bit         wr;
    logic [1:0] wc;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic v(input bit rn, e, u, s, c, l, input logic [2:0] lv,
                   input bit etc, input logic [2:0] ec, input bit ew,
                   input logic [1:0] ewc, input string nm);
    exp_t it;
    @(posedge clk); #1;
    rst_n = rn; en = e; up = u; sat = s; clr = c; load = l; load_val = lv;
    it.tc = etc; it.cnt = ec; it.wr = ew; it.wc = ewc; it.nm = nm;
    q.push_back(it);
  endtask

  // driver: directed vectors
  initial begin
    int         c5;
    logic [1:0] w5;
    // reset and free up-count through a wrap
    v(0,0,0,0,0,0,0, 0, 0,0,0, "rst0");
    v(0,0,0,0,0,0,0, 0, 0,0,0, "rst1");
    v(1,1,1,0,0,0,0, 0, 1,0,0, "up0");
    v(1,1,1,0,0,0,0, 0, 2,0,0, "up1");
    v(1,1,1,0,0,0,0, 0, 3,0,0, "up2");
    v(1,1,1,0,0,0,0, 0, 4,0,0, "up3");
    v(1,1,1,0,0,0,0, 0, 5,0,0, "up4");
    v(1,1,1,0,0,0,0, 1, 0,1,1, "up5wrap");
    v(1,1,1,0,0,0,0, 0, 1,0,1, "up0b");
    // down wrap and down saturate
    v(1,1,0,0,0,0,0, 0, 0,0,1, "dn1");
    v(1,1,0,0,0,0,0, 1, 5,1,2, "dn0wrap");
    v(1,0,0,0,0,1,0, 0, 0,0,2, "load0");
    v(1,1,0,1,0,0,0, 1, 0,0,2, "dnsat0");
    v(1,1,0,1,0,0,0, 1, 0,0,2, "dnsat1");
    // load clamp, load over en, clr over load
    v(1,0,0,0,0,1,7, 0, 5,0,2, "load7clamp");
    v(1,0,1,0,0,0,0, 0, 5,0,2, "hold_noen");
    v(1,1,1,0,0,1,3, 1, 3,0,2, "load_vs_en");
    v(1,0,0,0,1,1,2, 0, 0,0,0, "clr_vs_load");
    // saturate up then switch to wrap
    v(1,0,0,0,0,1,3, 0, 3,0,0, "load3");
    v(1,1,1,1,0,0,0, 0, 4,0,0, "sat3");
    v(1,1,1,1,0,0,0, 0, 5,0,0, "sat4");
    v(1,1,1,1,0,0,0, 1, 5,0,0, "sat5a");
    v(1,1,1,1,0,0,0, 1, 5,0,0, "sat5b");
    v(1,1,1,1,0,0,0, 1, 5,0,0, "sat5c");
    v(1,1,1,0,0,0,0, 1, 0,1,1, "unsat_wrap");
    v(1,0,1,0,0,0,0, 0, 0,0,1, "hold_clrwrap");
    // long run: wrap counter saturates at 3
    v(1,0,0,0,1,0,0, 0, 0,0,0, "clr_run");
    c5 = 0; w5 = 0;
    for (int i = 0; i < 34; i++) begin
      bit wr5;
      wr5 = (c5 == 5);
      if (wr5 && w5 != 2'd3) w5 = w5 + 1'b1;
      v(1,1,1,0,0,0,0, wr5, 3'((c5 + 1) % 6), wr5, w5, "run");
      c5 = (c5 + 1) % 6;
    end
    // reset mid-count (count=4) beats a load, then resume
    v(0,1,1,0,0,1,3, 0, 0,0,0, "rst_mid");
    v(1,1,1,0,0,0,0, 0, 1,0,0, "resume");
    @(posedge clk); #1;
    en = 1'b0;
    done = 1'b1;
  end

  // monitor: pops one expectation per cycle
  initial begin
    exp_t prev, cur;
    bit   have = 1'b0;
    int   cyc = 0;
    while (!(done && !have && q.size() == 0)) begin
      @(negedge clk);
      cyc++;
      if (cyc > 2000) begin
        n_chk++; n_fail++;
        $display("FAIL timeout: got %0d cycles expected <= 2000", cyc);
        break;
      end
      if (have) begin
        chk({prev.nm, ".count"},    int'(count),    int'(prev.cnt));
        chk({prev.nm, ".wrap"},     int'(wrap),     int'(prev.wr));
        chk({prev.nm, ".wrap_cnt"}, int'(wrap_cnt), int'(prev.wc));
      end
      if (q.size() != 0) begin
        cur = q.pop_front();
        chk({cur.nm, ".tc"}, int'(tc), int'(cur.tc));
        prev = cur;
        have = 1'b1;
      end else begin
        have = 1'b0;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
